// File: rtl/skid_buffer.sv
// Two-entry valid/ready pipeline stage with every output driven from a flop.
// Breaks both the forward valid/data path and the backward ready path.
module skid_buffer #(
  parameter int unsigned            WIDTH       = 8,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             s_ready_q, s_ready_d;
  logic             m_valid_q, m_valid_d;
  logic             insert, remove;

  assign insert  = s_valid & s_ready_q;
  assign remove  = m_valid_q & m_ready;

  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = main_q;

  // Next state and storage updates; flags look ahead at the next state.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (insert) begin
          main_d  = s_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (insert && remove) begin
          main_d = s_data;
        end else if (insert) begin
          skid_d  = s_data;
          state_d = FULL;
        end else if (remove) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (remove) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    s_ready_d = (state_d != FULL);
    m_valid_d = (state_d != EMPTY);
  end

  // State, data and flag registers; reset wins over any coincident transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      main_q    <= RESET_VALUE;
      skid_q    <= RESET_VALUE;
      s_ready_q <= 1'b1;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

endmodule

// File: tb/tb_skid_buffer.sv
// Scoreboard bench for skid_buffer: directed scenarios plus a random flow phase.
module tb_skid_buffer;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  int checks  = 0;
  int errors  = 0;
  int out_cnt = 0;
  int occ;
  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;
  logic [WIDTH-1:0] exp_q[$];

  skid_buffer #(.WIDTH(WIDTH), .RESET_VALUE(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Holds one set of inputs across one rising edge, returns just after it.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
    s_valid = v;
    s_data  = d;
    m_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Monitor: occupancy flags, ordered output, and hold stability.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      occ = exp_q.size();
      chk("m_valid_vs_occ", 32'(m_valid), 32'(occ != 0));
      chk("s_ready_vs_occ", 32'(s_ready), 32'(occ != 2));
      if (prev_hold) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none at %0t", m_data, $time);
        end else begin
          chk("out_order", 32'(m_data), 32'(exp_q.pop_front()));
        end
      end
      if (s_valid && s_ready) exp_q.push_back(s_data);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
    end
  end

  initial begin
    int c0;
    rst = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;

    // Reset held with traffic present, then first word after release
    drive(1'b1, 8'h99, 1'b1);
    drive(1'b1, 8'h99, 1'b1);
    rst = 1'b0;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'h00);
    drive(1'b1, 8'h11, 1'b1);
    chk("first_valid", 32'(m_valid), 32'd1);
    chk("first_data", 32'(m_data), 32'h11);
    drive(1'b0, 8'h00, 1'b1);
    chk("first_drained", 32'(m_valid), 32'd0);

    // Back-to-back streaming
    c0 = out_cnt;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      chk("stream_data", 32'(m_data), 32'(i));
      chk("stream_s_ready", 32'(s_ready), 32'd1);
    end
    drive(1'b0, 8'h00, 1'b1);
    chk("stream_count", 32'(out_cnt - c0), 32'd16);
    chk("stream_empty", 32'(m_valid), 32'd0);

    // Skid capture under backpressure
    drive(1'b1, 8'hA0, 1'b1);
    drive(1'b1, 8'hA1, 1'b0);
    chk("skid_data", 32'(m_data), 32'hA0);
    chk("skid_s_ready", 32'(s_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hA2, 1'b0);
      chk("skid_hold_data", 32'(m_data), 32'hA0);
      chk("skid_hold_ready", 32'(s_ready), 32'd0);
    end
    drive(1'b1, 8'hA2, 1'b1);
    chk("recover_data", 32'(m_data), 32'hA1);
    chk("recover_s_ready", 32'(s_ready), 32'd1);
    drive(1'b1, 8'hA2, 1'b1);
    chk("recover_a2", 32'(m_data), 32'hA2);
    drive(1'b0, 8'h00, 1'b1);
    chk("recover_empty", 32'(m_valid), 32'd0);

    // Reset while FULL discards both words
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b1, 8'h66, 1'b0);
    chk("full_s_ready", 32'(s_ready), 32'd0);
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b1);
    rst = 1'b0;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    chk("midrst_m_data", 32'(m_data), 32'h00);
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b1);

    // Random valid/ready against the scoreboard
    for (int i = 0; i < 2000; i++) begin
      drive(1'($urandom_range(0, 1)), 8'(i), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_m_valid", 32'(m_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
